seq_det_param: RTL and testbench
================================

Name: seq_det_param

Overview:
Parametrised Moore sequence detector that generalises the fixed 3-bit overlapping detector to an arbitrary LEN-bit pattern. Overlapping or non-overlapping detection is selectable at run time. A sample-enable allows stalled serial streams, and a saturating match counter is optional. It sits behind any serial bit source (UART/SPI deserialiser tap, test stimulus) as a pattern flag generator.

Parameters:
LEN, 3, pattern length in bits (legal 2..16)
PATTERN, 3'b101, LEN-bit target pattern; MSB is the first bit received
CNT_W, 8, width of match counter (legal 1..32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
x  input  1  serial input bit, sampled when en=1
en  input  1  sample enable; 0 = hold all state
ovl  input  1  mode: 1 = overlapping, 0 = non-overlapping
z  output  1  Moore detect flag, registered
match_cnt  output  CNT_W  number of detections, saturating

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset on the clk edge with reset=1:
  - state = S0; z = 0; match_cnt = 0.
  - Reset has priority over en.
  - Reset mid-pattern discards any partial prefix.
- States S0..S(LEN). Sk means the last k sampled bits equal the first k pattern bits.
  - SLEN is the detect state. z = 1 exactly when state = SLEN.
  - z is a pure function of the state register, with no combinational path from x.
- Transition on a rising edge with en=1 and reset=0:
  - From Sk, k<LEN: go to S(j). j is the length of the longest suffix of (matched prefix + x) that is also a pattern prefix (KMP failure function). Failure table is computed at elaboration from PATTERN.
  - From SLEN with ovl=1: same rule applied to the full matched pattern + x.
  - From SLEN with ovl=0: matched bits are consumed; the next state is S1 if x equals PATTERN[LEN-1], else S0.
- Latency:
  - z rises in the cycle after the edge that samples the final pattern bit.
  - z stays high until the next sampled edge, so it is one cycle wide when en is held at 1.
- en=0: state, z and match_cnt all hold; x is ignored.
- ovl is sampled only on a transition out of SLEN. Changing it mid-prefix has no effect on the current prefix.
- match_cnt:
  - Increments by 1 on every edge whose next state is SLEN, including SLEN to SLEN when overlapping allows it.
  - Saturates at 2^CNT_W-1 with no wrap.

Optional Feature:
SEQ_DET_MATCH_CNT_EN
- Defined: match_cnt counts and saturates as above.
- Undefined: no counter logic is built; match_cnt is tied to all zeros. Port list and z behaviour are unchanged.

Test Plan:
1. Defaults, ovl=1, en=1, reset for 2 cycles, then x=1,0,1,0,1. Required: z=1 in the cycles after bits 3 and 5, 0 elsewhere; match_cnt=2 (with SEQ_DET_MATCH_CNT_EN defined).
2. Defaults, ovl=0, same x stream 1,0,1,0,1. Required: z=1 only after bit 3; match_cnt=1. Follow with x=0,1: z=1 after that bit, match_cnt=2.
3. LEN=4, PATTERN=4'b1101, ovl=1, x=1,1,1,0,1. Required: state trace S1,S2,S2,S3,S4; z=1 only after bit 5. Follow with x=1,0,1: z=1 again after the last bit (overlap via S1).
4. Defaults, x=1,0; then en=0 for 3 cycles with x toggling; then en=1, x=1. Required: no z during the stall; z=1 after the final sampled bit; match_cnt=1. A further en=0 keeps z=1 held.
5. Defaults, x=1,0; then reset=1 for one cycle; then x=1. Required: z stays 0, match_cnt=0. Then x=0,1: z=1 after the last bit.
6. CNT_W=2, ovl=1, x=1,0,1,0,1,0,1,0,1,0,1 (5 matches). Required: match_cnt = 1,2,3,3,3; z still pulses on every match. With the macro undefined, match_cnt = 0 throughout and z is identical.

Source files
------------

// File: rtl/seq_det_param.sv
// seq_det_param: parametrised Moore detector for a LEN-bit serial pattern.
// The pattern arrives MSB first. Overlapping or non-overlapping detection is
// chosen at run time via ovl. Sampling is gated by en.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN builds the saturating match
// counter. Without it, match_cnt is tied to zero.
module seq_det_param #(
  parameter int unsigned      LEN     = 3,
  parameter logic [LEN-1:0]   PATTERN = 3'b101,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             ovl,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned ST_W   = $clog2(LEN + 1);
  localparam int unsigned CAND_W = LEN + 1;

  // State index k means the last k sampled bits equal the first k pattern bits.
  typedef logic [ST_W-1:0] state_t;

  localparam state_t S0    = '0;
  localparam state_t S1    = ST_W'(1);
  localparam state_t S_DET = ST_W'(LEN);

  // Reject illegal parameterisations at elaboration
  if (LEN < 2 || LEN > 16) begin : g_bad_len
    $error("seq_det_param: LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_det_param: CNT_W must be in 1..32");
  end

  // i-th received bit of the pattern (i = 0 is the first bit on the wire)
  function automatic logic pat_bit(input int unsigned i);
    logic [LEN-1:0] sh;
    sh = PATTERN >> (LEN - 1 - i);
    return sh[0];
  endfunction

  // Longest suffix of (first k pattern bits + b) that is also a pattern prefix
  function automatic int unsigned kmp_next(input int unsigned k, input logic b);
    logic [CAND_W-1:0] cand;
    logic [CAND_W-1:0] sh;
    logic              ok;
    int unsigned       res;
    cand = '0;
    res  = 0;
    for (int unsigned i = 0; i < k; i++) begin
      cand = cand | (CAND_W'(pat_bit(i)) << i);
    end
    cand = cand | (CAND_W'(b) << k);
    for (int unsigned j = 1; j <= LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int unsigned t = 0; t < j; t++) begin
          sh = cand >> (k + 1 - j + t);
          if (sh[0] != pat_bit(t)) ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  localparam logic FIRST_BIT = PATTERN[LEN-1];

  state_t state_q;
  state_t state_d;
  state_t nxt0 [LEN+1];
  state_t nxt1 [LEN+1];

  // Elaboration-time transition table: next state for each state and input bit
  for (genvar k = 0; k <= LEN; k++) begin : g_tbl
    assign nxt0[k] = ST_W'(kmp_next(k, 1'b0));
    assign nxt1[k] = ST_W'(kmp_next(k, 1'b1));
  end

  // Next-state logic; non-overlap leaving the detect state restarts from scratch
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (state_q == S_DET && !ovl) begin
        state_d = (x == FIRST_BIT) ? S1 : S0;
      end else begin
        for (int unsigned k = 0; k <= LEN; k++) begin
          if (state_q == ST_W'(k)) state_d = x ? nxt1[k] : nxt0[k];
        end
      end
    end
  end

  // State register and Moore flag, held while en is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      z       <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      z       <= (state_d == S_DET);
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of edges entering (or staying in) the detect state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en && state_d == S_DET && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: three instances (default 101, LEN=4
// 1101, CNT_W=2). Driver pushes expected post-edge outputs; a monitor pops
// and compares one entry per clock edge for each instance.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic [2:0] rst_v, x_v, en_v, ovl_v;
  logic [2:0] z_v;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  typedef struct {
    logic        z;
    int unsigned cnt;
    int          id;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          sid = 0;

  always #5 clk = ~clk;

  seq_det_param #(.LEN(3), .PATTERN(3'b101), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst_v[0]), .x(x_v[0]), .en(en_v[0]), .ovl(ovl_v[0]),
    .z(z_v[0]), .match_cnt(cnt_a));

  seq_det_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst_v[1]), .x(x_v[1]), .en(en_v[1]), .ovl(ovl_v[1]),
    .z(z_v[1]), .match_cnt(cnt_b));

  seq_det_param #(.LEN(3), .PATTERN(3'b101), .CNT_W(2)) dut_c (
    .clk(clk), .reset(rst_v[2]), .x(x_v[2]), .en(en_v[2]), .ovl(ovl_v[2]),
    .z(z_v[2]), .match_cnt(cnt_c));

  function automatic int unsigned ec(input int unsigned n);
`ifdef SEQ_DET_MATCH_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic cmp(input string tag, input logic az, input int unsigned ac, input exp_t e);
    n_total++;
    if (az === e.z && ac == e.cnt) n_pass++;
    else $display("FAIL %s step %0d: got z=%0b cnt=%0d, required z=%0b cnt=%0d",
                  tag, e.id, az, ac, e.z, e.cnt);
  endtask

  // Drive one cycle on instance d and queue the outputs expected after the edge
  task automatic step(input logic [1:0] d, input logic r, input logic xi, input logic e,
                      input logic o, input logic ez, input int unsigned ecn);
    exp_t ex;
    ex.z   = ez;
    ex.cnt = ec(ecn);
    ex.id  = sid;
    sid++;
    rst_v[d] = r;
    x_v[d]   = xi;
    en_v[d]  = e;
    ovl_v[d] = o;
    case (d)
      2'd0:    q_a.push_back(ex);
      2'd1:    q_b.push_back(ex);
      default: q_c.push_back(ex);
    endcase
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare each instance's outputs just after every clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin e = q_a.pop_front(); cmp("a", z_v[0], 32'(cnt_a), e); end
      if (q_b.size() > 0) begin e = q_b.pop_front(); cmp("b", z_v[1], 32'(cnt_b), e); end
      if (q_c.size() > 0) begin e = q_c.pop_front(); cmp("c", z_v[2], 32'(cnt_c), e); end
    end
  end

  initial begin
    rst_v = '1; x_v = '0; en_v = '0; ovl_v = '0;
    #2;

    // Overlapping 10101: detect after bits 3 and 5
    step(0, 1, 0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 1, 1, 2);

    // Non-overlapping 10101 then 01
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 0, 1, 2);

    // Stall with en=0, then finish the pattern, hold, reset beats en=0
    step(0, 1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1, 1, 1);
    step(0, 1, 0, 0, 1, 0, 0);

    // Reset mid-pattern discards the prefix
    step(0, 1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 1, 1);

    // ovl toggled mid-prefix has no effect; only sampled leaving detect
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 1, 1, 2);

    // LEN=4 1101 overlapping: 11101 then 101
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 1, 1);
    step(1, 0, 1, 1, 1, 0, 1);
    step(1, 0, 0, 1, 1, 0, 1);
    step(1, 0, 1, 1, 1, 1, 2);

    // LEN=4 non-overlapping: 1101 then 101 must not detect, 1101 does
    step(1, 1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 1, 1);
    step(1, 0, 1, 1, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 1, 1, 0, 0, 1);
    step(1, 0, 1, 1, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 1, 1, 0, 1, 2);

    // CNT_W=2: five overlapping matches saturate the counter at 3
    step(2, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      int unsigned m;
      m = (i >= 2) ? 32'(i / 2) : 0;
      if (m > 3) m = 3;
      step(2, 0, (i % 2) == 0, 1, 1, (i >= 2) && ((i % 2) == 0), m);
    end

    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) n_pass++;
    else $display("FAIL drain: pending a=%0d b=%0d c=%0d, required 0",
                  q_a.size(), q_b.size(), q_c.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
